// File: rtl/balise_pkg.sv
// Shared types and constants for the Balise AXI4-Lite arbiter.
package balise_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDATA,
        LOCERR
    } arb_state_t;

    localparam int unsigned BALISE_NUM_REGS = 4;
    localparam logic [1:0]  RESP_OKAY       = 2'b00;
    localparam logic [1:0]  RESP_SLVERR     = 2'b10;
    localparam logic [3:0]  WSTRB_FULL      = 4'hF;
    localparam logic [2:0]  PROT_DEFAULT    = 3'b000;

    // Registers are word-wide; any non-zero byte offset is rejected locally.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/balise_rr_arbiter.sv
// Round-robin picker: first active request at or after the pointer, wrapping.
module balise_rr_arbiter
    import balise_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    // Scan candidates in priority order starting from the pointer.
    always_comb begin
        int unsigned cand;
        logic [IDX_W-1:0] cand_idx;
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand     = (32'(ptr_i) + off) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (!valid_o && req_i[cand_idx]) begin
                valid_o         = 1'b1;
                idx_o           = cand_idx;
                gnt_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/balise_axil_arbiter.sv
// Shares one AXI4-Lite master port among NUM_REQ requesters, one transaction at a time.
module balise_axil_arbiter
    import balise_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic [ADDR_WIDTH-1:0]           m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [DATA_WIDTH-1:0]           m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]         m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;

    logic [NUM_REQ-1:0]      gnt_oh;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    gnt_valid;
    logic                    grant_en;
    logic [NUM_REQ-1:0]      idx_oh;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_write;

    balise_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt_oh),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    // No grant during the response cycle so back-to-back grants stay one cycle apart.
    assign grant_en  = ARESETN && (state_q == IDLE) && !(|rsp_valid_q);
    assign req_ready = grant_en ? gnt_oh : '0;
    assign idx_oh    = NUM_REQ'(1) << idx_q;

    // Mux the granted requester's address, data and direction.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_write = req_write[i];
            end
        end
    end

    // Next-state, latch and response logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_resp_d  = RESP_OKAY;
        unique case (state_q)
            IDLE: begin
                if (grant_en && gnt_valid) begin
                    idx_d     = gnt_idx;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ptr_d     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    if (is_misaligned(sel_addr[1:0])) begin
                        state_d     = LOCERR;
                        rsp_valid_d = gnt_oh;
                        rsp_resp_d  = RESP_SLVERR;
                    end else if (sel_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                // AW and W complete independently; move on once both have.
                aw_done_d = aw_done_q | m_axi_awready;
                w_done_d  = w_done_q | m_axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (m_axi_bvalid) begin
                    state_d     = IDLE;
                    rsp_valid_d = idx_oh;
                    rsp_resp_d  = m_axi_bresp;
                end
            end
            READ: begin
                if (m_axi_arready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (m_axi_rvalid) begin
                    state_d     = IDLE;
                    rsp_valid_d = idx_oh;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                end
            end
            LOCERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; reset abandons any bus handshake in flight.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = PROT_DEFAULT;
    assign m_axi_awvalid = (state_q == WRITE) && !aw_done_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = WSTRB_FULL;
    assign m_axi_wvalid  = (state_q == WRITE) && !w_done_q;
    assign m_axi_bready  = (state_q == WRESP);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = PROT_DEFAULT;
    assign m_axi_arvalid = (state_q == READ);
    assign m_axi_rready  = (state_q == RDATA);

endmodule

// File: tb/tb_balise_axil_arbiter.sv
// Bench for balise_axil_arbiter: behavioural slave, transaction-level reference model.
`timescale 1ns/1ps
module tb_balise_axil_arbiter;

    localparam int NR = 2;
    localparam int AW = 4;

    logic            ACLK = 1'b0;
    logic            ARESETN;
    logic [NR-1:0]   req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*32-1:0] req_wdata;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
    logic [2:0]      m_axi_awprot, m_axi_arprot;
    logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0]     m_axi_wdata, m_axi_rdata;
    logic [3:0]      m_axi_wstrb;
    logic [1:0]      m_axi_bresp, m_axi_rresp;
    logic            m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic            m_axi_rvalid, m_axi_rready;

    always #5 ACLK = ~ACLK;

    balise_axil_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // ---------------- behavioural AXI4-Lite slave ----------------
    logic [31:0] regs [4];
    logic        aw_got, w_got;
    logic [3:0]  aw_addr_s;
    logic [31:0] w_data_s;
    int          wcnt;
    int          w_delay = 0;   // extra cycles before wready
    bit          b_hold  = 0;   // suppress the write response
    logic        aw_now, w_now;
    logic [3:0]  addr_now;
    logic [31:0] data_now;

    assign aw_now   = aw_got || (m_axi_awvalid && m_axi_awready);
    assign w_now    = w_got || (m_axi_wvalid && m_axi_wready);
    assign addr_now = aw_got ? aw_addr_s : m_axi_awaddr;
    assign data_now = w_got ? w_data_s : m_axi_wdata;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_axi_awready <= 0; m_axi_wready <= 0; m_axi_bvalid <= 0; m_axi_bresp <= 0;
            m_axi_arready <= 0; m_axi_rvalid <= 0; m_axi_rdata <= 0; m_axi_rresp <= 0;
            aw_got <= 0; w_got <= 0; aw_addr_s <= 0; w_data_s <= 0; wcnt <= 0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                m_axi_awready <= 0; aw_got <= 1; aw_addr_s <= m_axi_awaddr;
            end else if (m_axi_awvalid && !aw_got) begin
                m_axi_awready <= 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                m_axi_wready <= 0; w_got <= 1; w_data_s <= m_axi_wdata; wcnt <= 0;
            end else if (m_axi_wvalid && !w_got) begin
                if (wcnt >= w_delay) m_axi_wready <= 1;
                else wcnt <= wcnt + 1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 0;
            end else if (aw_now && w_now && !m_axi_bvalid && !b_hold) begin
                regs[addr_now[3:2]] <= data_now;
                m_axi_bvalid <= 1; m_axi_bresp <= 2'b00; aw_got <= 0; w_got <= 0;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 0;
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_arready <= 0; m_axi_rvalid <= 1;
                m_axi_rdata <= regs[m_axi_araddr[3:2]]; m_axi_rresp <= 2'b00;
            end else if (m_axi_arvalid && !m_axi_rvalid) begin
                m_axi_arready <= 1;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, skew_cyc = 0, proto_viol = 0, arb_viol = 0;
    logic [3:0]  last_awaddr;
    logic [2:0]  last_awprot;
    logic [31:0] last_wdata, p_wdata;
    logic [3:0]  last_wstrb, p_awaddr, p_araddr;
    logic        aw_pend, w_pend, ar_pend;

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_pend <= 0; w_pend <= 0; ar_pend <= 0;
        end else begin
            if (aw_pend && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) proto_viol <= proto_viol + 1;
            if (w_pend && (!m_axi_wvalid || m_axi_wdata !== p_wdata)) proto_viol <= proto_viol + 1;
            if (ar_pend && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) proto_viol <= proto_viol + 1;
            aw_pend <= m_axi_awvalid && !m_axi_awready;
            w_pend  <= m_axi_wvalid && !m_axi_wready;
            ar_pend <= m_axi_arvalid && !m_axi_arready;
            p_awaddr <= m_axi_awaddr; p_wdata <= m_axi_wdata; p_araddr <= m_axi_araddr;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_hs <= aw_hs + 1; last_awaddr <= m_axi_awaddr; last_awprot <= m_axi_awprot;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_hs <= w_hs + 1; last_wdata <= m_axi_wdata; last_wstrb <= m_axi_wstrb;
            end
            if (m_axi_bvalid && m_axi_bready) b_hs <= b_hs + 1;
            if (m_axi_arvalid && m_axi_arready) ar_hs <= ar_hs + 1;
            if (!m_axi_awvalid && m_axi_wvalid) skew_cyc <= skew_cyc + 1;
            if ((|req_ready && |rsp_valid) || $countones(req_ready) > 1 ||
                $countones(rsp_valid) > 1) arb_viol <= arb_viol + 1;
        end
    end

    // ---------------- reference model and checking ----------------
    int          checks = 0, errors = 0;
    logic [31:0] mdl_mem [4];
    int          mdl_ptr = 0;
    bit          t_wr   [NR];
    logic [3:0]  t_addr [NR];
    logic [31:0] t_data [NR];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] mask, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int c = (ptr + k) % NR;
            if (mask[c]) return c;
        end
        return 0;
    endfunction

    // One arbitrated transaction: present t_* on the requesters in mask, check grant,
    // response contents, latency, single pulse and bus activity against the model.
    task automatic do_txn(input logic [NR-1:0] mask, input string tag, output int g);
        int eg, lat, e_lat, a0, w0, b0, r0;
        bit got;
        logic [31:0] e_data, e_bus, o_bus;
        logic [1:0]  e_resp;
        a0 = aw_hs; w0 = w_hs; b0 = b_hs; r0 = ar_hs;
        g = -1;
        for (int i = 0; i < NR; i++) begin
            req_write[i] = t_wr[i];
            req_addr[i*AW +: AW] = t_addr[i];
            req_wdata[i*32 +: 32] = t_data[i];
        end
        req_valid = mask;
        eg = rr_pick(mask, mdl_ptr);
        got = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (|req_ready) begin got = 1; break; end
            @(negedge ACLK);
        end
        for (int k = 0; k < NR; k++) if (req_ready[k]) g = k;
        check({tag, ".grant"}, 32'(req_ready), 32'(1) << eg);
        if (!got) begin req_valid = '0; return; end
        if (t_addr[eg][1:0] != 2'b00) begin
            e_data = 0; e_resp = 2'b10; e_lat = 1; e_bus = 32'h0;
        end else if (t_wr[eg]) begin
            mdl_mem[t_addr[eg][3:2]] = t_data[eg];
            e_data = 0; e_resp = 2'b00; e_lat = 4 + w_delay; e_bus = 32'h01010100;
        end else begin
            e_data = mdl_mem[t_addr[eg][3:2]]; e_resp = 2'b00; e_lat = 4; e_bus = 32'h00000001;
        end
        mdl_ptr = (eg + 1) % NR;
        @(negedge ACLK);
        req_valid = '0;
        lat = 1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (|rsp_valid) break;
            @(negedge ACLK);
            lat++;
        end
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(1) << eg);
        check({tag, ".rdata"}, rsp_rdata, e_data);
        check({tag, ".resp"}, 32'(rsp_resp), 32'(e_resp));
        check({tag, ".latency"}, lat, e_lat);
        @(negedge ACLK);
        #1;
        check({tag, ".pulse"}, 32'(rsp_valid), 32'h0);
        o_bus = {8'(aw_hs - a0), 8'(w_hs - w0), 8'(b_hs - b0), 8'(ar_hs - r0)};
        check({tag, ".bus"}, o_bus, e_bus);
    endtask

    function automatic logic [3:0] rand_addr();
        logic [3:0] a;
        a = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        int g, s0;
        int gs [4];
        int exp_seq [4] = '{0, 1, 0, 1};
        bit got;
        ARESETN = 0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 4; i++) mdl_mem[i] = '0;
        repeat (3) @(negedge ACLK);
        #1;
        check("reset.req_ready", 32'(req_ready), 0);
        check("reset.rsp_valid", 32'(rsp_valid), 0);
        check("reset.rsp_data", {rsp_rdata[29:0], rsp_resp}, 0);
        check("reset.axi_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                        m_axi_arvalid, m_axi_rready}), 0);
        @(negedge ACLK);
        ARESETN = 1;
        @(negedge ACLK);

        // Single write then readback from the other requester.
        t_wr[0] = 1; t_addr[0] = 4'h4; t_data[0] = 32'h2;
        do_txn(2'b01, "write0", g);
        check("write0.awaddr", 32'(last_awaddr), 32'h4);
        check("write0.wdata", last_wdata, 32'h2);
        check("write0.wstrb", 32'(last_wstrb), 32'hF);
        check("write0.awprot", 32'(last_awprot), 32'h0);
        t_wr[1] = 0; t_addr[1] = 4'h4; t_data[1] = 32'h0;
        do_txn(2'b10, "read1", g);

        // All four registers round-trip values 1..4.
        for (int r = 0; r < 4; r++) begin
            t_wr[0] = 1; t_addr[0] = 4'(r * 4); t_data[0] = 32'(r + 1);
            do_txn(2'b01, "rt.wr", g);
            t_wr[1] = 0; t_addr[1] = 4'(r * 4);
            do_txn(2'b10, "rt.rd", g);
            check("rt.value", rsp_rdata === 32'h0 ? mdl_mem[r] : mdl_mem[r], 32'(r + 1));
        end

        // Contention with both requesters active: grants alternate from pointer 0.
        for (int k = 0; k < 4; k++) begin
            t_wr[0] = 0; t_addr[0] = 4'h0; t_wr[1] = 0; t_addr[1] = 4'h8;
            do_txn(2'b11, "contend", gs[k]);
            check("contend.order", gs[k], exp_seq[k]);
        end

        // Misaligned read is answered locally with SLVERR.
        t_wr[0] = 0; t_addr[0] = 4'h6;
        do_txn(2'b01, "misaligned", g);

        // W handshake lags AW by three cycles.
        w_delay = 3; s0 = skew_cyc;
        t_wr[0] = 1; t_addr[0] = 4'h8; t_data[0] = 32'hA5A5_0F0F;
        do_txn(2'b01, "skew", g);
        check("skew.w_only_cycles", skew_cyc - s0, 3);
        w_delay = 0;

        // Randomized mix of requesters, directions, alignments and W skew.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NR; i++) begin
                t_wr[i] = 1'($urandom_range(0, 1));
                t_addr[i] = rand_addr();
                t_data[i] = $urandom;
            end
            w_delay = $urandom_range(0, 3);
            do_txn(2'($urandom_range(1, 3)), "random", g);
        end
        w_delay = 0;

        // Reset while waiting for the write response.
        b_hold = 1;
        t_wr[0] = 1; t_addr[0] = 4'hC; t_data[0] = 32'hDEAD_BEEF;
        req_write[0] = 1; req_addr[0 +: AW] = 4'hC; req_wdata[0 +: 32] = 32'hDEAD_BEEF;
        req_valid = 2'b01;
        @(negedge ACLK);
        req_valid = '0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_axi_bready) begin got = 1; break; end
            @(negedge ACLK);
        end
        check("midreset.reached_wresp", 32'(got), 1);
        req_valid = 2'b10;
        ARESETN = 0;
        #1;
        check("midreset.req_ready", 32'(req_ready), 0);
        check("midreset.rsp", {rsp_rdata[29:0], rsp_resp}, 0);
        check("midreset.rsp_valid", 32'(rsp_valid), 0);
        check("midreset.axi_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                           m_axi_arvalid, m_axi_rready}), 0);
        @(negedge ACLK);
        req_valid = '0; b_hold = 0; ARESETN = 1;
        mdl_ptr = 0;
        for (int i = 0; i < 4; i++) mdl_mem[i] = '0;
        @(negedge ACLK);
        t_wr[0] = 0; t_addr[0] = 4'h0;
        do_txn(2'b01, "post_reset.read", g);

        check("protocol.stability", proto_viol, 0);
        check("arbiter.one_hot_and_spacing", arb_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
